fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the controller/datapath. Holds the PC and issues word requests to instruction memory over a req/ready handshake. Latches the returned word and presents it with decoded controller fields (cond, op, funct, rd). Advances the PC to PC+4, or to a branch target when the controller asserts pc_src, on the cycle the instruction is consumed.

Parameters:
ADDR_W, 32, PC and memory address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, fetch watchdog limit; used only with FETCH_TIMEOUT_EN

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  word-aligned fetch address (always the current PC)
imem_ready  input  1  memory handshake; imem_rdata valid when imem_req && imem_ready
imem_rdata  input  32  fetched instruction word
stall  input  1  downstream not accepting; hold the current instruction
pc_src  input  1  controller branch/PC-write decision; sampled only on consume
branch_target  input  ADDR_W  next PC when pc_src is taken
instr_valid  output  1  instr and decoded fields valid
instr  output  32  latched instruction
pc  output  ADDR_W  address of the latched instruction
pc_plus8  output  ADDR_W  pc + 8 (R15 read value)
cond  output  4  instr[31:28]
op  output  2  instr[27:26]
funct  output  6  instr[25:20]
rd  output  4  instr[15:12]
fetch_err  output  1  sticky watchdog error; constant 0 without FETCH_TIMEOUT_EN

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, watchdog count=0. imem_req is forced to 0 while reset is low.
- FETCH state:
  - imem_req=1, imem_addr=pc. The address stays stable until the handshake.
  - On imem_req && imem_ready: instr<=imem_rdata and go to VALID. If ready is seen in cycle N, instr_valid=1 from cycle N+1.
  - Ready in the first cycle after reset release is legal. Zero-wait memory gives 1 instruction per 2 cycles.
- VALID state:
  - instr_valid=1, imem_req=0.
  - stall=1: all state held. pc_src and branch_target are ignored.
  - stall=0 (consume): pc<=pc_src ? {branch_target[ADDR_W-1:2],2'b00} : pc+4. Then go to FETCH. instr_valid drops the next cycle.
- pc_src is ignored in FETCH state. A branch is applied only on consume.
- Arithmetic: pc+4 and pc+8 wrap modulo 2^ADDR_W. Example: pc=32'hFFFF_FFFC gives pc+4=0 and pc_plus8=4.
- The low 2 bits of branch_target are always discarded. The PC is always word-aligned.
- Decoded fields are combinational slices of the instr register, so they read 0 after reset.
- Reset asserted mid-fetch or mid-stall: the transaction is abandoned with no further req that cycle. After release, the fetch restarts at RESET_PC. A late imem_ready seen while in reset is ignored.
- imem_ready while imem_req=0 (VALID state) is ignored. instr is not overwritten.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter increments each FETCH cycle with imem_req=1 && imem_ready=0. It clears on handshake.
  - When the counter reaches TIMEOUT_CYCLES, fetch_err<=1. fetch_err is sticky until reset.
  - The fetch keeps waiting; no retry and no abort.
  - The counter saturates at TIMEOUT_CYCLES.
- Undefined: no counter logic; fetch_err tied 0; the fetch waits indefinitely.

Test Plan:
- Reset release, memory returns 32'hE080_2003 with zero wait:
  - imem_addr=0 in cycle 1 after release; instr_valid=1 in cycle 2.
  - cond=4'hE, op=0, funct=6'h08, rd=4'h2, pc=0, pc_plus8=8.
- Sequential run of 3 instructions, stall=0, pc_src=0: imem_addr sequence is 0,4,8; each instr_valid pulse lasts 1 cycle.
- Branch: at pc=8, pc_src=1 with branch_target=32'h0000_0103 on consume. Next imem_addr=32'h0000_0100. pc_src=1 asserted during FETCH has no effect.
- Stall for 5 cycles in VALID:
  - instr, pc and instr_valid are held and imem_req=0.
  - Toggling pc_src during the stall is ignored.
  - On release the PC advances to pc+4.
- Memory wait of 3 cycles, then reset pulsed low during the 2nd wait cycle:
  - imem_req=0 immediately and pc=RESET_PC.
  - After release, the fetch restarts at address 0.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold imem_ready=0:
  - fetch_err=0 through 15 wait cycles; fetch_err=1 after the 16th.
  - It stays 1 after a later handshake until reset.
- Wrap check: RESET_PC=32'hFFFF_FFFC; after the first consume, imem_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ready fetch from instruction memory, instruction latch and field decode.
// Optional fetch watchdog (sticky fetch_err_o) enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned       TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [31:0]       imem_rdata_i,
    input  logic              stall_i,
    input  logic              pc_src_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus8_o,
    output logic [3:0]        cond_o,
    output logic [1:0]        op_o,
    output logic [5:0]        funct_o,
    output logic [3:0]        rd_o,
    output logic              fetch_err_o
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_VALID = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;

    // Next-state: capture on handshake, redirect or step the PC on consume
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready_i) begin
                    instr_d = imem_rdata_i;
                    state_d = S_VALID;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_VALID: begin
                if (!stall_i) begin
                    pc_d    = pc_src_i ? {branch_target_i[ADDR_W-1:2], 2'b00}
                                       : pc_q + ADDR_W'(32'd4);
                    state_d = S_FETCH;
                end else begin
                    state_d = S_VALID;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State, PC and instruction registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Request is gated by reset so an in-flight fetch is dropped the moment reset asserts
    assign imem_req_o    = reset_ni & (state_q == S_FETCH);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (state_q == S_VALID);
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign pc_plus8_o    = pc_q + ADDR_W'(32'd8);
    assign cond_o        = instr_q[31:28];
    assign op_o          = instr_q[27:26];
    assign funct_o       = instr_q[25:20];
    assign rd_o          = instr_q[15:12];

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned    WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            fetch_err_q, fetch_err_d;
    logic            unused_s;

    // Watchdog: count unanswered fetch cycles, saturate, flag sticky error at the limit
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == S_FETCH) begin
            if (imem_ready_i) begin
                wd_cnt_d = {WD_W{1'b0}};
            end else if (wd_cnt_q != WD_MAX) begin
                wd_cnt_d = wd_cnt_q + WD_W'(1'b1);
            end else begin
                wd_cnt_d = wd_cnt_q;
            end
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
        fetch_err_d = fetch_err_q | (wd_cnt_d == WD_MAX);
    end

    // Watchdog registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wd_cnt_q    <= {WD_W{1'b0}};
            fetch_err_q <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err_o = fetch_err_q;
    assign unused_s    = ^branch_target_i[1:0];
`else
    logic unused_s;

    assign fetch_err_o = 1'b0;
    assign unused_s    = ^{branch_target_i[1:0], 1'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a transaction-level reference model predicts the
// fetch address and delivered-instruction streams; a negedge monitor pops and compares.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        fetch_err;

`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    fetch_unit dut (
        .clk_i          (clk),
        .reset_ni       (rst_n),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ready_i   (imem_ready),
        .imem_rdata_i   (imem_rdata),
        .stall_i        (stall),
        .pc_src_i       (pc_src),
        .branch_target_i(branch_target),
        .instr_valid_o  (instr_valid),
        .instr_o        (instr),
        .pc_o           (pc),
        .pc_plus8_o     (pc_plus8),
        .cond_o         (cond),
        .op_o           (op),
        .funct_o        (funct),
        .rd_o           (rd),
        .fetch_err_o    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'hE080_2003;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor / scoreboard
    initial begin
        logic        p_req, p_ready, p_valid, p_stall;
        logic [31:0] cur_addr;
        exp_t        cur;
        p_req = 1'b0; p_ready = 1'b0; p_valid = 1'b0; p_stall = 1'b0;
        cur_addr = 32'h0; cur = '{32'h0, 32'h0};
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("fetch_err_quiet", {31'h0, fetch_err}, 32'h0);
                chk("req_xor_valid", {31'h0, imem_req}, {31'h0, !instr_valid});
                if (imem_req) begin
                    if (!p_req) begin
                        if (addr_q.size() == 0) fail_now("addr_queue_underflow");
                        else cur_addr = addr_q.pop_front();
                    end
                    chk("imem_addr", imem_addr, cur_addr);
                end
                if (instr_valid && !p_valid) begin
                    chk("valid_follows_handshake", {31'h0, p_req && p_ready}, 32'h1);
                    if (exp_q.size() == 0) fail_now("instr_queue_underflow");
                    else begin
                        cur = exp_q.pop_front();
                        chk("instr", instr, cur.ins);
                        chk("pc", pc, cur.pc);
                        chk("pc_plus8", pc_plus8, cur.pc + 32'd8);
                        chk("cond", {28'h0, cond}, {28'h0, cur.ins[31:28]});
                        chk("op", {30'h0, op}, {30'h0, cur.ins[27:26]});
                        chk("funct", {26'h0, funct}, {26'h0, cur.ins[25:20]});
                        chk("rd", {28'h0, rd}, {28'h0, cur.ins[15:12]});
                    end
                end else if (instr_valid) begin
                    chk("valid_held_only_on_stall", {31'h0, p_stall}, 32'h1);
                    chk("instr_hold", instr, cur.ins);
                    chk("pc_hold", pc, cur.pc);
                end else begin
                    chk("valid_missing_after_handshake", {31'h0, p_req && p_ready}, 32'h0);
                end
                p_req = imem_req; p_ready = imem_ready; p_valid = instr_valid; p_stall = stall;
            end
        end
    end

    // Stimulus and reference model
    initial begin
        logic [31:0] m_pc;
        bit          m_holding;
        int          wait_cnt, delivered, guard;

        rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = 32'h0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus8", pc_plus8, 32'h8);
        chk("rst_fields", {18'h0, cond, op, funct, rd}, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);

        repeat (2) @(posedge clk);
        #2;
        m_pc = 32'h0; m_holding = 1'b0; wait_cnt = 0; delivered = 0;
        addr_q.push_back(32'h0);
        rst_n = 1'b1; mon_en = 1'b1; imem_ready = 1'b1;

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            if (!m_holding) begin
                if (imem_ready) begin
                    exp_q.push_back('{m_pc, mem_word(m_pc)});
                    m_holding = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (!stall) begin
                m_pc = pc_src ? (branch_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
                addr_q.push_back(m_pc);
                m_holding = 1'b0;
                delivered++;
            end
            #2;
            imem_ready = (wait_cnt >= 4) ? 1'b1 : ($urandom_range(0, 99) < 55);
            stall      = ($urandom_range(0, 99) < 40);
            pc_src     = ($urandom_range(0, 99) < 30);
            case ($urandom_range(0, 3))
                0:       branch_target = 32'h0000_0103;
                1:       branch_target = 32'hFFFF_FFFF;
                2:       branch_target = 32'hFFFF_FFF6;
                default: branch_target = $urandom;
            endcase
        end
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("addr_queue_drained", addr_q.size(), 32'h0);
        chk("instr_queue_drained", exp_q.size(), 32'h0);
        chk("enough_consumes", {31'h0, delivered > 100}, 32'h1);

        // Reset abandoned mid-fetch, late ready ignored, then watchdog on the restarted fetch
        imem_ready = 1'b0; stall = 1'b0; pc_src = 1'b0;
        guard = 0;
        while (guard < 20) begin
            @(negedge clk);
            if (imem_req) break;
            guard++;
        end
        if (guard >= 20) fail_now("timeout_waiting_for_fetch");
        @(posedge clk);
        #2;
        rst_n = 1'b0; imem_ready = 1'b1;
        #1;
        chk("midrst_req", {31'h0, imem_req}, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_ready_ignored_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_ready_ignored_instr", instr, 32'h0);
        #1;
        imem_ready = 1'b0; rst_n = 1'b1;
        #1;
        chk("restart_req", {31'h0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("wd_err_wait%0d", i), {31'h0, fetch_err}, {31'h0, TO_EN && (i >= 16)});
        end
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        imem_ready = 1'b0; stall = 1'b1;
        chk("first_valid", {31'h0, instr_valid}, 32'h1);
        chk("first_instr", instr, 32'hE080_2003);
        chk("first_cond", {28'h0, cond}, 32'hE);
        chk("first_op", {30'h0, op}, 32'h0);
        chk("first_funct", {26'h0, funct}, 32'h08);
        chk("first_rd", {28'h0, rd}, 32'h2);
        chk("first_pc", pc, 32'h0);
        chk("first_pc_plus8", pc_plus8, 32'h8);
        chk("err_sticky_after_hs", {31'h0, fetch_err}, {31'h0, TO_EN});
        @(posedge clk);
        #1;
        chk("err_sticky_later", {31'h0, fetch_err}, {31'h0, TO_EN});
        chk("stall_holds_valid", {31'h0, instr_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("err_cleared_by_reset", {31'h0, fetch_err}, 32'h0);
        chk("valid_cleared_by_reset", {31'h0, instr_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
